// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory program loader: FSM state
// encoding, word geometry and the big-endian byte lane helper.
package loader_pkg;

    typedef enum logic [2:0] {
        LOAD_CNT,
        LOAD_DATA,
        WRITE,
        RUN,
        ERR
    } loader_state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

    // Bit position of the low end of byte lane idx; byte 0 is the MSB lane.
    function automatic logic [4:0] lane_lsb(input logic [BYTE_CNT_W-1:0] idx);
        return 5'd24 - {idx, 3'b000};
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Collects four stream bytes into one big-endian 32-bit word. The completed
// word and its valid pulse are presented in the same cycle as the fourth byte
// so the loader can register it straight into the imem port.
module word_assembler
    import loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [31:0]           shift_q, shift_d;

    // Drop each accepted byte into its lane and advance the byte counter.
    always_comb begin
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        if (byte_valid_i) begin
            shift_d[lane_lsb(byte_cnt_q) +: 8] = byte_i;
            byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
        end
    end

    assign word_o       = shift_d;
    assign word_valid_o = byte_valid_i && (byte_cnt_q == BYTE_CNT_W'(BYTES_PER_WORD - 1));

    // Hold partial words indefinitely; reset or reload throws them away.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            byte_cnt_q <= '0;
            shift_q    <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
        end
    end

endmodule

// File: rtl/imem_program_loader.sv
// Byte-stream program loader: reads a word count N, then N instruction words,
// writes them to imem[0..N-1] while holding the CPU in reset, then lets it run.
module imem_program_loader
    import loader_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    input  logic [7:0]        in_data_i,
    output logic              in_ready_o,
    input  logic              reload_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              cpu_hold_o,
    output logic              done_o,
    output logic              error_o
);

    loader_state_e     state_q;
    logic [ADDR_W:0]   word_cnt_q;
    logic [ADDR_W:0]   n_q;
    logic [ADDR_W:0]   word_cnt_inc;
    logic              in_ready_q;
    logic              imem_we_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [31:0]       imem_wdata_q;
    logic              cpu_hold_q;
    logic              done_q;
    logic              error_q;

    logic              byte_fire;
    logic              reload_fire;
    logic [31:0]       word;
    logic              word_valid;

    assign byte_fire    = in_valid_i && in_ready_q;
    assign reload_fire  = reload_i && (state_q == RUN);
    assign word_cnt_inc = word_cnt_q + (ADDR_W + 1)'(1);

    word_assembler u_asm (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clr_i        (reload_fire),
        .byte_valid_i (byte_fire),
        .byte_i       (in_data_i),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    // Loader FSM; every output is registered so in_ready never depends on in_valid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= LOAD_CNT;
            word_cnt_q   <= '0;
            n_q          <= '0;
            in_ready_q   <= 1'b1;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            case (state_q)
                LOAD_CNT: begin
                    if (word_valid) begin
                        if (word == 32'd0 || word > 32'(MAX_WORDS)) begin
                            state_q    <= ERR;
                            error_q    <= 1'b1;
                            in_ready_q <= 1'b0;
                        end else begin
                            n_q        <= word[ADDR_W:0];
                            word_cnt_q <= '0;
                            state_q    <= LOAD_DATA;
                        end
                    end
                end
                LOAD_DATA: begin
                    if (word_valid) begin
                        state_q      <= WRITE;
                        imem_we_q    <= 1'b1;
                        imem_addr_q  <= word_cnt_q[ADDR_W-1:0];
                        imem_wdata_q <= word;
                        in_ready_q   <= 1'b0;
                    end
                end
                WRITE: begin
                    imem_we_q <= 1'b0;
                    if (word_cnt_inc == n_q) begin
                        state_q    <= RUN;
                        cpu_hold_q <= 1'b0;
                        done_q     <= 1'b1;
                    end else begin
                        word_cnt_q <= word_cnt_inc;
                        in_ready_q <= 1'b1;
                        state_q    <= LOAD_DATA;
                    end
                end
                RUN: begin
                    if (reload_i) begin
                        state_q    <= LOAD_CNT;
                        cpu_hold_q <= 1'b1;
                        done_q     <= 1'b0;
                        in_ready_q <= 1'b1;
                        word_cnt_q <= '0;
                        n_q        <= '0;
                    end
                end
                ERR: begin
                    error_q    <= 1'b1;
                    in_ready_q <= 1'b0;
                    cpu_hold_q <= 1'b1;
                end
                default: begin
                    state_q    <= ERR;
                    error_q    <= 1'b1;
                    in_ready_q <= 1'b0;
                    cpu_hold_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready_o   = in_ready_q;
    assign imem_we_o    = imem_we_q;
    assign imem_addr_o  = imem_addr_q;
    assign imem_wdata_o = imem_wdata_q;
    assign cpu_hold_o   = cpu_hold_q;
    assign done_o       = done_q;
    assign error_o      = error_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Self-checking bench for imem_program_loader: streams programs byte by byte
// with random gaps and compares imem writes and status flags against a simple
// model of what a loaded program should look like.
module tb_imem_program_loader;

    localparam int ADDR_W    = 10;
    localparam int MAX_WORDS = 1024;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              inValid = 1'b0;
    logic [7:0]        inData = 8'h00;
    logic              reload = 1'b0;
    logic              inReady;
    logic              imemWe;
    logic [ADDR_W-1:0] imemAddr;
    logic [31:0]       imemWdata;
    logic              cpuHold;
    logic              done;
    logic              error;

    int checks   = 0;
    int failures = 0;

    logic [ADDR_W-1:0] gotAddr[$];
    logic [31:0]       gotData[$];
    logic [31:0]       prog[$];

    imem_program_loader #(
        .ADDR_W    (ADDR_W),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_valid_i   (inValid),
        .in_data_i    (inData),
        .in_ready_o   (inReady),
        .reload_i     (reload),
        .imem_we_o    (imemWe),
        .imem_addr_o  (imemAddr),
        .imem_wdata_o (imemWdata),
        .cpu_hold_o   (cpuHold),
        .done_o       (done),
        .error_o      (error)
    );

    always #5 clk = ~clk;

    // Record every imem write the loader performs.
    always @(negedge clk) begin
        if (!rst && imemWe) begin
            gotAddr.push_back(imemAddr);
            gotData.push_back(imemWdata);
        end
    end

    // Safety net so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        rst     = 1'b1;
        inValid = 1'b0;
        reload  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        gotAddr.delete();
        gotData.delete();
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " in_ready"}, 32'(inReady), 32'd1);
        checkOutput({tag, " imem_we"}, 32'(imemWe), 32'd0);
        checkOutput({tag, " imem_addr"}, 32'(imemAddr), 32'd0);
        checkOutput({tag, " imem_wdata"}, imemWdata, 32'd0);
        checkOutput({tag, " cpu_hold"}, 32'(cpuHold), 32'd1);
        checkOutput({tag, " done"}, 32'(done), 32'd0);
        checkOutput({tag, " error"}, 32'(error), 32'd0);
    endtask

    // Offer one byte, optionally after a random idle gap; returns at the
    // falling edge after the byte has been accepted.
    task automatic sendByte(input logic [7:0] b, input int maxGap);
        int gap;
        int waited;
        gap = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
        repeat (gap) begin
            inValid = 1'b0;
            inData  = 8'($urandom);
            @(negedge clk);
        end
        inValid = 1'b1;
        inData  = b;
        waited  = 0;
        while (!inReady && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!inReady) begin
            checkOutput("handshake timeout", 32'd0, 32'd1);
            inValid = 1'b0;
            return;
        end
        @(negedge clk);
        inValid = 1'b0;
        inData  = 8'($urandom);
    endtask

    task automatic sendWord(input logic [31:0] w, input int maxGap);
        for (int k = 0; k < 4; k++) begin
            sendByte(w[31-8*k -: 8], maxGap);
        end
    endtask

    // Compare the recorded writes with imem[i] = prog[i] for i < n.
    task automatic verifyWrites(input int n);
        int lim;
        checkOutput("write count", 32'(gotAddr.size()), 32'(n));
        lim = (gotAddr.size() < n) ? gotAddr.size() : n;
        for (int i = 0; i < lim; i++) begin
            checkOutput("write addr", 32'(gotAddr[i]), 32'(i));
            checkOutput("write data", gotData[i], prog[i]);
        end
    endtask

    // Stream count n followed by the first n words of prog and check the
    // response expected from the count: error, or n writes then RUN.
    task automatic applyStimulus(input logic [31:0] n, input int maxGap);
        bit expErr;
        expErr = (n == 32'd0) || (n > 32'(MAX_WORDS));
        gotAddr.delete();
        gotData.delete();
        sendWord(n, maxGap);
        if (expErr) begin
            checkOutput("err flag", 32'(error), 32'd1);
            checkOutput("err in_ready", 32'(inReady), 32'd0);
            checkOutput("err cpu_hold", 32'(cpuHold), 32'd1);
            checkOutput("err done", 32'(done), 32'd0);
            repeat (5) @(negedge clk);
            checkOutput("err no write", 32'(gotAddr.size()), 32'd0);
            checkOutput("err sticky", 32'(error), 32'd1);
            return;
        end
        checkOutput("count no error", 32'(error), 32'd0);
        for (int i = 0; i < int'(n); i++) begin
            sendWord(prog[i], maxGap);
            checkOutput("we after word", 32'(imemWe), 32'd1);
            checkOutput("addr after word", 32'(imemAddr), 32'(i));
            checkOutput("data after word", imemWdata, prog[i]);
            checkOutput("hold while loading", 32'(cpuHold), 32'd1);
        end
        checkOutput("done during last write", 32'(done), 32'd0);
        @(negedge clk);
        checkOutput("run cpu_hold", 32'(cpuHold), 32'd0);
        checkOutput("run done", 32'(done), 32'd1);
        checkOutput("run in_ready", 32'(inReady), 32'd0);
        checkOutput("run we low", 32'(imemWe), 32'd0);
        repeat (4) @(negedge clk);
        verifyWrites(int'(n));
    endtask

    initial begin
        $display("[TB] start");
        doReset();
        checkResetState("reset");

        // Basic load
        prog = '{32'h20010005, 32'h2002000A, 32'hAC010000};
        applyStimulus(32'd3, 0);

        // Same program with random gaps between bytes
        doReset();
        applyStimulus(32'd3, 5);

        // Bad counts, then a good load after reset
        doReset();
        applyStimulus(32'd0, 2);
        doReset();
        applyStimulus(32'(MAX_WORDS + 1), 2);
        doReset();
        prog.delete();
        for (int i = 0; i < 6; i++) prog.push_back($urandom);
        applyStimulus(32'd6, 3);

        // Maximum length program
        doReset();
        prog.delete();
        for (int i = 0; i < MAX_WORDS; i++) prog.push_back($urandom);
        applyStimulus(32'(MAX_WORDS), 0);

        // Reset in the middle of a data word
        doReset();
        sendWord(32'd1, 0);
        sendByte(8'h11, 0);
        sendByte(8'h22, 0);
        rst = 1'b1;
        @(negedge clk);
        checkResetState("mid-word reset");
        rst = 1'b0;
        gotAddr.delete();
        gotData.delete();
        prog = '{32'hCAFEF00D};
        applyStimulus(32'd1, 2);

        // Reload from RUN, with an ignored reload pulse during LOAD_DATA
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        checkOutput("reload cpu_hold", 32'(cpuHold), 32'd1);
        checkOutput("reload done", 32'(done), 32'd0);
        checkOutput("reload in_ready", 32'(inReady), 32'd1);
        gotAddr.delete();
        gotData.delete();
        prog = '{32'hDEADBEEF};
        sendWord(32'd1, 1);
        sendByte(8'hDE, 1);
        sendByte(8'hAD, 1);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        checkOutput("reload ignored hold", 32'(cpuHold), 32'd1);
        sendByte(8'hBE, 1);
        sendByte(8'hEF, 1);
        checkOutput("reload we", 32'(imemWe), 32'd1);
        checkOutput("reload addr", 32'(imemAddr), 32'd0);
        checkOutput("reload data", imemWdata, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("reload done again", 32'(done), 32'd1);
        checkOutput("reload cpu run", 32'(cpuHold), 32'd0);
        repeat (3) @(negedge clk);
        verifyWrites(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
